mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, memory line address width.
REQ-002 SHALL have parameter LINE_W, default 128, cache line width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit; used only when MEM_ARB_TIMEOUT_EN is defined.
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 i_req_in / d_req_in  in  1  icache / dcache memory request, held high until ready.
REQ-007 i_we_in / d_we_in  in  1  request is a write-back.
REQ-008 i_addr_in / d_addr_in  in  ADDR_W  line address.
REQ-009 i_data_in / d_data_in  in  LINE_W  write-back data.
REQ-010 i_ready_out / d_ready_out  out  1  completion pulse to the granted requester.
REQ-011 i_data_out / d_data_out  out  LINE_W  fill data; valid when the matching ready is high.
REQ-012 mem_req_out, mem_we_out  out  1  shared-port request and write enable.
REQ-013 mem_addr_out  out  ADDR_W; mem_data_out  out  LINE_W  shared-port address and write data.
REQ-014 mem_ready_in  in  1; mem_data_in  in  LINE_W  memory completion pulse and read data.
REQ-015 timeout_err_out  out  1  watchdog error pulse; tied 0 when the feature is compiled out.

Function
REQ-016 States: IDLE, GRANT_I, GRANT_D. The state register is the only grant storage.
REQ-017 In IDLE, with exactly one requester high, the next state grants that requester.
REQ-018 In IDLE, with both requesters high, the next state grants the requester not served last (round-robin); the last_grant flag resets to icache, so dcache wins the first tie.
REQ-019 Grant latency: a request seen in IDLE at cycle n drives mem_req_out at cycle n+1; no combinational path from req to mem_req_out while in IDLE.
REQ-020 In GRANT_x, mem_req_out/we/addr/data SHALL equal the granted requester's inputs combinationally; in IDLE they SHALL all be 0.
REQ-021 In GRANT_x, x_ready_out SHALL equal mem_ready_in and x_data_out SHALL equal mem_data_in in the same cycle; the non-granted ready SHALL be 0 and its data 0.
REQ-022 On mem_ready_in in GRANT_x: update last_grant to x and return to IDLE, except under the write-back lock.
REQ-023 Write-back lock: if the completed transfer had we=1, the next grant SHALL go to the same requester when its req is high in the following IDLE cycle, overriding round-robin; the lock clears after that grant or when the requester's req is low.
REQ-024 Abort: if the granted requester drops req before mem_ready_in, return to IDLE next cycle, leave last_grant unchanged, and produce no ready pulse.
REQ-025 mem_ready_in while in IDLE SHALL be ignored, with no ready pulse to either requester.
REQ-026 Abort and ready in the same cycle SHALL be treated as completion: forward the ready.

Reset
REQ-027 Asserting reset at any time, including mid-grant, SHALL force IDLE, clear last_grant to icache, clear the lock and the watchdog, and drive all outputs to 0 without waiting for a clock edge.
REQ-028 An in-flight transfer SHALL NOT be replayed after reset.

Configuration
REQ-029 With MEM_ARB_TIMEOUT_EN defined: a counter clears on each grant and increments every GRANT_x cycle without mem_ready_in.
REQ-030 With MEM_ARB_TIMEOUT_EN defined: when the count reaches TIMEOUT_CYCLES, pulse timeout_err_out for 1 cycle, drop the grant to IDLE, update last_grant, and send no ready pulse.
REQ-031 Without MEM_ARB_TIMEOUT_EN: no counter logic is generated, timeout_err_out is constant 0, and a grant waits indefinitely.

Structure
REQ-032 State encodings and the ICACHE/DCACHE requester IDs SHALL live in the shared definitions file alongside the cache state defines.
REQ-033 The block is a single module with no sub-module; the round-robin pick is inline logic.

Verification
REQ-034 Idle, then d_req at cycle 2 with addr 0x00040 -> mem_req_out=1 and mem_addr_out=0x00040 at cycle 3; mem_ready_in at cycle 6 with data 0xA5.. -> d_ready_out=1 and d_data_out=0xA5.. at cycle 6; IDLE at cycle 7.
REQ-035 i_req and d_req rise together after reset -> dcache granted first, icache next; repeat -> alternation D, I, D, I.
REQ-036 dcache write-back (we=1, addr 0x00100) completes while i_req is pending and d_req stays high for the fill -> dcache granted again (lock), then icache.
REQ-037 Granted icache drops req 2 cycles into the grant -> IDLE next cycle, no i_ready_out pulse; a later mem_ready_in is ignored.
REQ-038 reset low during GRANT_D -> outputs 0 immediately, state IDLE; after reset high with both requesting -> dcache wins.
REQ-039 MEM_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, memory never ready -> timeout_err_out pulses once at the 8th grant cycle, grant released, no ready pulse.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter and the caches that sit in front of it:
// arbiter state encodings, requester IDs and cache line state encodings.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_GRANT_I = 2'b01,
    ST_GRANT_D = 2'b10
  } arb_state_e;

  typedef enum logic {
    REQ_ICACHE = 1'b0,
    REQ_DCACHE = 1'b1
  } req_id_e;

  // Line states used by the icache/dcache controllers
  typedef enum logic [1:0] {
    CL_INVALID = 2'b00,
    CL_CLEAN   = 2'b01,
    CL_DIRTY   = 2'b10
  } cache_line_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (icache/dcache) arbiter onto a single shared memory port.
// Optional watchdog compiled in with `define MEM_ARB_TIMEOUT_EN.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no grant; memory port driven to 0, pick next requester
// ST_GRANT_I | icache owns the memory port, waiting for mem_ready_in
// ST_GRANT_D | dcache owns the memory port, waiting for mem_ready_in
//
// The state register is the only grant storage, so the shared-port outputs
// are a pure mux of the granted requester's inputs and fall to 0 the moment
// reset forces ST_IDLE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = 20,
  parameter int LINE_W         = 128,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_in,
  input  logic              i_we_in,
  input  logic [ADDR_W-1:0] i_addr_in,
  input  logic [LINE_W-1:0] i_data_in,
  input  logic              d_req_in,
  input  logic              d_we_in,
  input  logic [ADDR_W-1:0] d_addr_in,
  input  logic [LINE_W-1:0] d_data_in,
  output logic              i_ready_out,
  output logic [LINE_W-1:0] i_data_out,
  output logic              d_ready_out,
  output logic [LINE_W-1:0] d_data_out,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [LINE_W-1:0] mem_data_out,
  input  logic              mem_ready_in,
  input  logic [LINE_W-1:0] mem_data_in,
  output logic              timeout_err_out
);

  arb_state_e state_q, state_d;
  req_id_e    last_q, last_d;
  logic       lock_q, lock_d;
  req_id_e    lock_id_q, lock_id_d;

  logic    gnt_i, gnt_d, gnt_req, gnt_we;
  req_id_e gnt_id;
  logic    tmo_hit;

  assign gnt_i   = (state_q == ST_GRANT_I);
  assign gnt_d   = (state_q == ST_GRANT_D);
  assign gnt_id  = gnt_d ? REQ_DCACHE : REQ_ICACHE;
  assign gnt_req = gnt_i ? i_req_in : (gnt_d ? d_req_in : 1'b0);
  assign gnt_we  = gnt_i ? i_we_in  : (gnt_d ? d_we_in  : 1'b0);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // Watchdog: held at 0 in IDLE so every grant starts from zero, counts stalled grant cycles
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_IDLE) begin
      tmo_cnt_d = '0;
    end else if (!mem_ready_in) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  // Watchdog count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Fires in the grant cycle that would bring the count to TIMEOUT_CYCLES.
  // An aborting requester is not reported: it is already going away.
  assign tmo_hit = gnt_req && !mem_ready_in &&
                   (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err_out = tmo_hit;
`else
  assign tmo_hit = 1'b0;
  // Parameter kept so both builds share one interface; folds to constant 0.
  assign timeout_err_out = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  // Next-state: write-back lock, then round-robin in IDLE; completion/abort/timeout when granted
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    case (state_q)
      ST_IDLE: begin
        // The lock only lives for the first IDLE cycle after a write-back.
        lock_d = 1'b0;
        if (lock_q && (lock_id_q == REQ_DCACHE) && d_req_in) begin
          state_d = ST_GRANT_D;
        end else if (lock_q && (lock_id_q == REQ_ICACHE) && i_req_in) begin
          state_d = ST_GRANT_I;
        end else if (i_req_in && d_req_in) begin
          state_d = (last_q == REQ_ICACHE) ? ST_GRANT_D : ST_GRANT_I;
        end else if (i_req_in) begin
          state_d = ST_GRANT_I;
        end else if (d_req_in) begin
          state_d = ST_GRANT_D;
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        if (mem_ready_in) begin
          // Completion wins over a same-cycle abort.
          state_d   = ST_IDLE;
          last_d    = gnt_id;
          lock_d    = gnt_we;
          lock_id_d = gnt_id;
        end else if (!gnt_req) begin
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
          last_d  = gnt_id;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant state, round-robin history and write-back lock registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      last_q    <= REQ_ICACHE;
      lock_q    <= 1'b0;
      lock_id_q <= REQ_ICACHE;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end

  assign mem_req_out  = gnt_req;
  assign mem_we_out   = gnt_we;
  assign mem_addr_out = gnt_i ? i_addr_in : (gnt_d ? d_addr_in : '0);
  assign mem_data_out = gnt_i ? i_data_in : (gnt_d ? d_data_in : '0);

  assign i_ready_out = gnt_i & mem_ready_in;
  assign d_ready_out = gnt_d & mem_ready_in;
  assign i_data_out  = gnt_i ? mem_data_in : '0;
  assign d_data_out  = gnt_d ? mem_data_in : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change 1 ns after the rising edge and
// outputs are checked 2 ns later, well before the next edge.
module tb_mem_arbiter;

  localparam int AW = 20;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_we, d_req, d_we;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] i_wdata, d_wdata;
  logic          i_ready, d_ready;
  logic [LW-1:0] i_rdata, d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_ready;
  logic [LW-1:0] mem_rdata;
  logic          tmo_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(
    .ADDR_W(AW),
    .LINE_W(LW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .i_req_in(i_req),
    .i_we_in(i_we),
    .i_addr_in(i_addr),
    .i_data_in(i_wdata),
    .d_req_in(d_req),
    .d_we_in(d_we),
    .d_addr_in(d_addr),
    .d_data_in(d_wdata),
    .i_ready_out(i_ready),
    .i_data_out(i_rdata),
    .d_ready_out(d_ready),
    .d_data_out(d_rdata),
    .mem_req_out(mem_req),
    .mem_we_out(mem_we),
    .mem_addr_out(mem_addr),
    .mem_data_out(mem_wdata),
    .mem_ready_in(mem_ready),
    .mem_data_in(mem_rdata),
    .timeout_err_out(tmo_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // who: 0 = no grant, 1 = icache, 2 = dcache
  task automatic expect_grant(input string tag, input int who);
    logic [AW-1:0] ea;
    ea = (who == 1) ? i_addr : ((who == 2) ? d_addr : '0);
    check({tag, ":req"}, mem_req, (who != 0));
    check({tag, ":addr"}, mem_addr, ea);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    i_req     = 1'b0;
    i_we      = 1'b0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    i_addr    = 20'h11111;
    d_addr    = 20'h22222;
    i_wdata   = {4{32'h1111_2222}};
    d_wdata   = {4{32'hDDDD_0001}};
    mem_ready = 1'b0;
    mem_rdata = '0;
    settle();
    check("rst:mem_req", mem_req, 0);
    check("rst:i_ready", i_ready, 0);
    check("rst:d_ready", d_ready, 0);
    check("rst:tmo", tmo_err, 0);
    tick();
    tick();
    reset = 1'b1;

    // Single dcache read: one cycle grant latency, same-cycle ready forwarding
    tick();
    d_req  = 1'b1;
    d_addr = 20'h00040;
    settle();
    check("lat:no_comb_req", mem_req, 0);
    tick();
    settle();
    expect_grant("lat:grant", 2);
    tick();
    tick();
    settle();
    expect_grant("lat:hold", 2);
    mem_ready = 1'b1;
    mem_rdata = {16{8'hA5}};
    settle();
    check("rd:d_ready", d_ready, 1);
    check("rd:d_data", d_rdata, {16{8'hA5}});
    check("rd:i_ready", i_ready, 0);
    check("rd:i_data", i_rdata, 0);
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    d_req     = 1'b0;
    settle();
    expect_grant("rd:idle", 0);

    // Round-robin from reset: D, I, D, I with both held high
    reset = 1'b0;
    tick();
    reset  = 1'b1;
    d_addr = 20'h22222;
    i_req  = 1'b1;
    d_req  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      settle();
      expect_grant($sformatf("rr%0d", k), (k % 2 == 0) ? 2 : 1);
      mem_ready = 1'b1;
      settle();
      if (k % 2 == 0) check($sformatf("rr%0d:d_ready", k), d_ready, 1);
      else            check($sformatf("rr%0d:i_ready", k), i_ready, 1);
      tick();
      mem_ready = 1'b0;
      settle();
      expect_grant($sformatf("rr%0d:idle", k), 0);
    end
    i_req = 1'b0;
    d_req = 1'b0;

    // Write-back lock: dcache regains the port even though icache is due
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 20'h00100;
    d_wdata = {4{32'hCAFE_F00D}};
    tick();
    settle();
    expect_grant("wb:grant", 2);
    check("wb:we", mem_we, 1);
    check("wb:data", mem_wdata, {4{32'hCAFE_F00D}});
    i_req = 1'b1;
    tick();
    mem_ready = 1'b1;
    settle();
    check("wb:d_ready", d_ready, 1);
    tick();
    mem_ready = 1'b0;
    d_we      = 1'b0;
    settle();
    expect_grant("wb:idle", 0);
    tick();
    settle();
    expect_grant("wb:lock", 2);
    check("wb:fill_we", mem_we, 0);
    mem_ready = 1'b1;
    settle();
    tick();
    mem_ready = 1'b0;
    d_req     = 1'b0;
    tick();
    settle();
    expect_grant("wb:then_i", 1);
    mem_ready = 1'b1;
    mem_rdata = {4{32'h0BAD_BEEF}};
    settle();
    check("wb:i_ready", i_ready, 1);
    check("wb:i_data", i_rdata, {4{32'h0BAD_BEEF}});
    tick();
    mem_ready = 1'b0;
    i_req     = 1'b0;

    // icache abort two cycles into its grant; later ready is ignored
    i_req = 1'b1;
    tick();
    settle();
    expect_grant("ab:grant", 1);
    tick();
    i_req = 1'b0;
    settle();
    check("ab:mem_req", mem_req, 0);
    check("ab:i_ready", i_ready, 0);
    tick();
    settle();
    expect_grant("ab:idle", 0);
    mem_ready = 1'b1;
    settle();
    check("ab:late_i_ready", i_ready, 0);
    check("ab:late_d_ready", d_ready, 0);
    tick();
    mem_ready = 1'b0;
    settle();
    expect_grant("ab:no_replay", 0);

    // dcache abort must not move round-robin history (last stays icache)
    d_req = 1'b1;
    tick();
    settle();
    expect_grant("abd:grant", 2);
    d_req = 1'b0;
    settle();
    check("abd:d_ready", d_ready, 0);
    tick();
    settle();
    expect_grant("abd:idle", 0);
    i_req = 1'b1;
    d_req = 1'b1;
    tick();
    settle();
    expect_grant("abd:tie_d", 2);

    // Abort and ready in the same cycle count as completion
    d_req     = 1'b0;
    mem_ready = 1'b1;
    settle();
    check("abr:d_ready", d_ready, 1);
    tick();
    mem_ready = 1'b0;
    tick();
    settle();
    expect_grant("abr:next_i", 1);
    // icache aborts so last stays dcache going into reset
    i_req = 1'b0;
    d_req = 1'b1;
    tick();
    tick();
    settle();
    expect_grant("rs:grant_d", 2);

    // Reset mid-grant: outputs drop without a clock edge
    mem_ready = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check("rs:mem_req", mem_req, 0);
    check("rs:mem_addr", mem_addr, 0);
    check("rs:d_ready", d_ready, 0);
    check("rs:d_data", d_rdata, 0);
    mem_ready = 1'b0;
    tick();
    tick();
    i_req = 1'b1;
    reset = 1'b1;
    tick();
    settle();
    expect_grant("rs:tie_d", 2);
    mem_ready = 1'b1;
    settle();
    tick();
    mem_ready = 1'b0;
    d_req     = 1'b0;
    tick();
    settle();

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: error on the 8th grant cycle, grant dropped
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("tmo:err_c%0d", k), tmo_err, (k == 8));
      check($sformatf("tmo:i_ready_c%0d", k), i_ready, 0);
      if (k != 8) begin
        tick();
        settle();
      end
    end
    tick();
    settle();
    expect_grant("tmo:released", 0);
    check("tmo:err_gone", tmo_err, 0);
    i_req = 1'b0;
`else
    // No watchdog: a stalled grant is held indefinitely
    for (int k = 0; k < 20; k++) begin
      tick();
    end
    settle();
    expect_grant("notmo:held", 1);
    check("notmo:err", tmo_err, 0);
    mem_ready = 1'b1;
    settle();
    check("notmo:i_ready", i_ready, 1);
    tick();
    mem_ready = 1'b0;
    i_req     = 1'b0;
`endif
    tick();
    settle();
    expect_grant("end:idle", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
